arp_eth_rx_queue: RTL
=====================

// Module: arp_eth_rx_queue
// PURPOSE
//  ARP receive parser with output queue, target-IP filtering and statistics.
//  Accepts an Ethernet frame as a parallel header plus an AXI-stream payload,
//  extracts and validates the 28-byte ARP header, and pushes accepted frames into an internal FIFO.
//  Never backpressures on a full queue: the frame is dropped and counted. Sits between eth_demux and arp.
// PARAMETERS
//  DATA_WIDTH     8                 payload width in bits; must equal KEEP_WIDTH*8
//  KEEP_ENABLE    (DATA_WIDTH>8)    use tkeep; if 0, all lanes are treated as valid
//  KEEP_WIDTH     (DATA_WIDTH/8)    number of byte lanes
//  FIFO_DEPTH     4                 parsed-frame queue depth; power of 2, >=2
//  FILTER_ENABLE  1                 1 = drop frames whose tpa != local_ip
//  CNT_WIDTH      16                statistics counter width
// PORTS
//  clk                        in   1           clock
//  rst_n                      in   1           asynchronous reset, active-low
//  s_eth_hdr_valid/ready      in/out 1         Ethernet header handshake
//  s_eth_dest_mac,s_eth_src_mac in 48          Ethernet header MAC addresses
//  s_eth_type                 in   16          Ethernet type field
//  s_eth_payload_axis_tdata   in   DATA_WIDTH  payload data; byte k is in lane k%KEEP_WIDTH
//  s_eth_payload_axis_tkeep   in   KEEP_WIDTH  payload byte enables
//  s_eth_payload_axis_tvalid/tready in/out 1   payload handshake
//  s_eth_payload_axis_tlast/tuser   in   1     end of frame / frame bad
//  m_frame_valid/ready        out/in 1         queue head handshake
//  m_eth_dest_mac,m_eth_src_mac out 48         queue-head Ethernet MAC addresses
//  m_eth_type                 out  16          queue-head Ethernet type
//  m_arp_htype,m_arp_ptype,m_arp_oper out 16   queue-head ARP fields
//  m_arp_hlen,m_arp_plen      out  8           queue-head ARP lengths
//  m_arp_sha,m_arp_tha        out  48          queue-head sender/target MAC
//  m_arp_spa,m_arp_tpa        out  32          queue-head sender/target IP
//  local_ip                   in   32          filter address; sampled at commit
//  fifo_count                 out  $clog2(FIFO_DEPTH)+1  queue occupancy
//  rx_frame_count, drop_filter_count, drop_full_count  out CNT_WIDTH  statistics
//  busy                       out  1           state != IDLE
//  error_header_early_termination, error_invalid_header  out 1  1-cycle pulses
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; FIFO empty; all counters 0; all status and ready outputs 0.
//   Partial frame discarded, nothing counted. Field outputs are don't-care while m_frame_valid=0.
//  States:
//   IDLE : hdr_ready=1; hdr handshake stores eth fields, ptr=0 -> HDR.
//   HDR  : tready=1; beat with ptr p writes header byte k (p==k/KEEP_WIDTH and tkeep[k%KEEP_WIDTH]).
//          Fields big-endian; ptr++ per beat; after byte 27 -> DRAIN unless tlast.
//   DRAIN: tready=1; discard beats until tlast.
//   Any tlast beat -> IDLE, with the commit decision below.
//  hdr_ready/tready are registered: first hdr_ready=1 on first clk edge after rst_n release.
//   Zero-bubble restart: hdr_ready=1 the cycle after tlast.
//  Commit on the tlast beat, first match wins:
//   1. byte 27 not received   -> error_header_early_termination pulse
//   2. tuser=1                -> silent drop
//   3. htype!=1 | ptype!=0x0800 | hlen!=6 | plen!=4 -> error_invalid_header pulse
//   4. FILTER_ENABLE & tpa!=local_ip -> drop_filter_count++
//   5. fifo_count==FIFO_DEPTH (registered; a same-cycle pop does not free space) -> drop_full_count++
//   6. otherwise push, rx_frame_count++; m_frame_valid=1 the cycle after the tlast beat.
//  Error pulses last 1 cycle, registered, in the cycle after the tlast beat.
//  FIFO: m_frame_valid = !empty; head fields stable while valid & !ready; pop on valid & ready.
//   Simultaneous push+pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Counters saturate at 2^CNT_WIDTH-1 (no wrap).
//  Ethernet header bypass: eth fields travel in the FIFO entry with the ARP fields.
// TESTING
//  1. DW=8, valid request, tpa=local_ip=0xC0A80180 -> one entry, sha/spa exact, rx_frame_count=1, m_frame_valid 1 cycle after tlast.
//  2. DW=64, 28-byte frame with tlast at byte 20 -> error_header_early_termination 1-cycle pulse, no push, no counters change.
//  3. hlen=8 or ptype=0x86DD -> error_invalid_header pulse; tpa=0x0A000001 vs local_ip=0xC0A80180 -> drop_filter_count=1.
//  4. m_frame_ready=0, 6 valid frames, FIFO_DEPTH=4 -> fifo_count=4, drop_full_count=2, head fields unchanged; hdr_ready never 0 for longer than a frame.
//  5. rst_n pulled low mid-HDR, then a new valid frame -> only the new frame is queued; all counters reflect the new frame only.
//  6. DW=32, tkeep=0x3 on the last beat after byte 27, tuser=1 -> silent drop; CNT_WIDTH=2 with 5 accepted frames -> rx_frame_count=3 (saturated).

Source files
------------

// File: rtl/arp_eth_rx_queue.sv
// ARP receive parser: gathers the 28-byte ARP header from an Ethernet payload stream,
// validates and filters it, and queues accepted frames; frames arriving to a full queue are dropped and counted.
module arp_eth_rx_queue #(
  parameter int DATA_WIDTH    = 8,
  parameter int KEEP_ENABLE   = (DATA_WIDTH > 8),
  parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
  parameter int FIFO_DEPTH    = 4,
  parameter int FILTER_ENABLE = 1,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          s_eth_hdr_valid,
  output logic                          s_eth_hdr_ready,
  input  logic [47:0]                   s_eth_dest_mac,
  input  logic [47:0]                   s_eth_src_mac,
  input  logic [15:0]                   s_eth_type,
  input  logic [DATA_WIDTH-1:0]         s_eth_payload_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]         s_eth_payload_axis_tkeep,
  input  logic                          s_eth_payload_axis_tvalid,
  output logic                          s_eth_payload_axis_tready,
  input  logic                          s_eth_payload_axis_tlast,
  input  logic                          s_eth_payload_axis_tuser,
  output logic                          m_frame_valid,
  input  logic                          m_frame_ready,
  output logic [47:0]                   m_eth_dest_mac,
  output logic [47:0]                   m_eth_src_mac,
  output logic [15:0]                   m_eth_type,
  output logic [15:0]                   m_arp_htype,
  output logic [15:0]                   m_arp_ptype,
  output logic [7:0]                    m_arp_hlen,
  output logic [7:0]                    m_arp_plen,
  output logic [15:0]                   m_arp_oper,
  output logic [47:0]                   m_arp_sha,
  output logic [31:0]                   m_arp_spa,
  output logic [47:0]                   m_arp_tha,
  output logic [31:0]                   m_arp_tpa,
  input  logic [31:0]                   local_ip,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [CNT_WIDTH-1:0]          rx_frame_count,
  output logic [CNT_WIDTH-1:0]          drop_filter_count,
  output logic [CNT_WIDTH-1:0]          drop_full_count,
  output logic                          busy,
  output logic                          error_header_early_termination,
  output logic                          error_invalid_header
);

  localparam int HDR_BYTES = 28;
  localparam int AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCW       = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, HDR, DRAIN} state_t;

  typedef struct packed {
    logic [15:0] htype;
    logic [15:0] ptype;
    logic [7:0]  hlen;
    logic [7:0]  plen;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [47:0] tha;
    logic [31:0] tpa;
  } arp_t;

  typedef struct packed {
    logic [47:0] dest_mac;
    logic [47:0] src_mac;
    logic [15:0] eth_type;
    arp_t        arp;
  } entry_t;

  state_t state, state_next;

  logic [KEEP_WIDTH-1:0]  keep;
  logic                   beat, commit;
  logic [HDR_BYTES*8-1:0] hdr_q, hdr_d;
  logic                   got_last_q, got_last_d;
  logic [5:0]             ptr;
  logic [47:0]            eth_dest_q, eth_src_q;
  logic [15:0]            eth_type_q;
  arp_t                   arp_d;
  entry_t                 entry_in, head;
  logic                   hdr_ok, ip_match, full, frame_ok, push, pop;

  entry_t                 mem [FIFO_DEPTH];
  logic [AW-1:0]          wr_ptr, rd_ptr;

  assign keep   = (KEEP_ENABLE != 0) ? s_eth_payload_axis_tkeep : '1;
  assign beat   = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;
  assign commit = beat && s_eth_payload_axis_tlast;
  assign busy   = (state != IDLE);

  // hdr_d holds byte k at the big-endian position, so it casts straight onto arp_t.
  always_comb begin
    hdr_d      = hdr_q;
    got_last_d = got_last_q;
    if (beat && state == HDR) begin
      for (int unsigned k = 0; k < HDR_BYTES; k++) begin
        if (ptr == 6'(k / KEEP_WIDTH) && 1'(keep >> (k % KEEP_WIDTH))) begin
          hdr_d[8*(HDR_BYTES-1-k) +: 8] = 8'(s_eth_payload_axis_tdata >> (8 * (k % KEEP_WIDTH)));
          if (k == HDR_BYTES - 1) got_last_d = 1'b1;
        end
      end
    end
  end

  assign arp_d             = hdr_d;
  assign entry_in.dest_mac = eth_dest_q;
  assign entry_in.src_mac  = eth_src_q;
  assign entry_in.eth_type = eth_type_q;
  assign entry_in.arp      = arp_d;

  assign hdr_ok   = (arp_d.htype == 16'd1) && (arp_d.ptype == 16'h0800) &&
                    (arp_d.hlen == 8'd6) && (arp_d.plen == 8'd4);
  assign ip_match = (FILTER_ENABLE == 0) || (arp_d.tpa == local_ip);
  assign full     = (fifo_count == FCW'(FIFO_DEPTH));
  assign frame_ok = commit && got_last_d && !s_eth_payload_axis_tuser;
  assign push     = frame_ok && hdr_ok && ip_match && !full;
  assign pop      = m_frame_valid && m_frame_ready;

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (s_eth_hdr_valid && s_eth_hdr_ready) state_next = HDR;
      HDR: begin
        if (beat) begin
          if (s_eth_payload_axis_tlast) state_next = IDLE;
          else if (got_last_d)          state_next = DRAIN;
        end
      end
      DRAIN:   if (commit) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                          <= IDLE;
      s_eth_hdr_ready                <= 1'b0;
      s_eth_payload_axis_tready      <= 1'b0;
      error_header_early_termination <= 1'b0;
      error_invalid_header           <= 1'b0;
      ptr                            <= '0;
      got_last_q                     <= 1'b0;
      hdr_q                          <= '0;
      eth_dest_q                     <= '0;
      eth_src_q                      <= '0;
      eth_type_q                     <= '0;
    end else begin
      state                          <= state_next;
      s_eth_hdr_ready                <= (state_next == IDLE);
      s_eth_payload_axis_tready      <= (state_next != IDLE);
      error_header_early_termination <= commit && !got_last_d;
      error_invalid_header           <= frame_ok && !hdr_ok;
      if (state == IDLE && s_eth_hdr_valid && s_eth_hdr_ready) begin
        eth_dest_q <= s_eth_dest_mac;
        eth_src_q  <= s_eth_src_mac;
        eth_type_q <= s_eth_type;
        ptr        <= '0;
        got_last_q <= 1'b0;
        hdr_q      <= '0;
      end else if (beat && state == HDR) begin
        hdr_q      <= hdr_d;
        got_last_q <= got_last_d;
        if (ptr != '1) ptr <= ptr + 6'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      fifo_count        <= '0;
      rx_frame_count    <= '0;
      drop_filter_count <= '0;
      drop_full_count   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + FCW'(1);
        2'b01:   fifo_count <= fifo_count - FCW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (push && rx_frame_count != '1)
        rx_frame_count <= rx_frame_count + CNT_WIDTH'(1);
      if (frame_ok && hdr_ok && !ip_match && drop_filter_count != '1)
        drop_filter_count <= drop_filter_count + CNT_WIDTH'(1);
      if (frame_ok && hdr_ok && ip_match && full && drop_full_count != '1)
        drop_full_count <= drop_full_count + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry_in;
  end

  assign m_frame_valid  = (fifo_count != '0);
  assign head           = mem[rd_ptr];
  assign m_eth_dest_mac = head.dest_mac;
  assign m_eth_src_mac  = head.src_mac;
  assign m_eth_type     = head.eth_type;
  assign m_arp_htype    = head.arp.htype;
  assign m_arp_ptype    = head.arp.ptype;
  assign m_arp_hlen     = head.arp.hlen;
  assign m_arp_plen     = head.arp.plen;
  assign m_arp_oper     = head.arp.oper;
  assign m_arp_sha      = head.arp.sha;
  assign m_arp_spa      = head.arp.spa;
  assign m_arp_tha      = head.arp.tha;
  assign m_arp_tpa      = head.arp.tpa;

endmodule
